// File: rtl/norm_div_pkg.sv
// Shared softmax constants: data/address widths, run length and IP latencies.
package norm_div_pkg;

  localparam int AW         = 12;
  localparam int DW         = 32;
  localparam int DATA_SIZE  = 128;

  // Fixed latencies of the floating-point cores used along the softmax datapath
  localparam int NORM_DELAY = 5;
  localparam int EXP_DELAY  = 17;
  localparam int ACC_DELAY  = 7;
  localparam int DIV_DELAY  = 14;

  // Canonical quiet NaN produced by the divider for invalid operations
  localparam logic [DW-1:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/norm_div_if.sv
// Handshake and memory-port bundle between norm_div and its neighbours.
interface norm_div_if;
  import norm_div_pkg::*;

  logic          norm_div_start;
  logic          norm_div_ready;
  logic [DW-1:0] sum;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ena;
  logic          downstream_ready;
  logic          norm_div_done;

  // Upstream controller / memories side
  modport master (
    output norm_div_start, sum, rd_data, downstream_ready,
    input  norm_div_ready, rd_addr, wr_addr, wr_data, wr_ena, norm_div_done
  );

  // norm_div side
  modport slave (
    input  norm_div_start, sum, rd_data, downstream_ready,
    output norm_div_ready, rd_addr, wr_addr, wr_data, wr_ena, norm_div_done
  );
endinterface

// File: rtl/fdiv14.sv
// Single-precision divider core with a fixed 14-cycle latency.
// Denormal operands are flushed to zero; rounding is to nearest even.
module fdiv14 (
  input  logic        clock,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);
  import norm_div_pkg::*;

  localparam int LAT = 14;

  logic               sign_s;
  logic [7:0]         ea_s, eb_s;
  logic [23:0]        ma_s, mb_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [24:0]        rem_s;
  logic [26:0]        q_s;
  logic [25:0]        norm_s;
  logic signed [9:0]  exp_s;
  logic               sticky_s, round_s;
  logic [23:0]        frac_s;
  logic [31:0]        quot_s;
  logic [31:0]        stage_r [LAT];

  // Unpipelined divide: mantissa long division, normalise, round, classify
  always_comb begin
    sign_s   = dataa[31] ^ datab[31];
    ea_s     = dataa[30:23];
    eb_s     = datab[30:23];
    ma_s     = {1'b1, dataa[22:0]};
    mb_s     = {1'b1, datab[22:0]};
    a_zero_s = (ea_s == 8'd0);
    b_zero_s = (eb_s == 8'd0);
    a_inf_s  = (ea_s == 8'hFF) && (dataa[22:0] == 23'd0);
    b_inf_s  = (eb_s == 8'hFF) && (datab[22:0] == 23'd0);
    a_nan_s  = (ea_s == 8'hFF) && (dataa[22:0] != 23'd0);
    b_nan_s  = (eb_s == 8'hFF) && (datab[22:0] != 23'd0);

    rem_s = {1'b0, ma_s};
    q_s   = 27'd0;
    for (int i = 26; i >= 0; i--) begin
      if (rem_s >= {1'b0, mb_s}) begin
        q_s[i] = 1'b1;
        rem_s  = rem_s - {1'b0, mb_s};
      end else begin
        q_s[i] = 1'b0;
      end
      rem_s = {rem_s[23:0], 1'b0};
    end

    exp_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
    if (q_s[26]) begin
      norm_s = q_s[25:0];
    end else begin
      norm_s = {q_s[24:0], 1'b0};
      exp_s  = exp_s - 10'sd1;
    end

    sticky_s = (|norm_s[1:0]) | (|rem_s);
    round_s  = norm_s[2] & (sticky_s | norm_s[3]);
    frac_s   = {1'b0, norm_s[25:3]} + {23'd0, round_s};
    if (frac_s[23]) begin
      exp_s = exp_s + 10'sd1;
    end else begin
      exp_s = exp_s;
    end

    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      quot_s = FP_QNAN;
    end else if (a_inf_s || b_zero_s) begin
      quot_s = {sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_inf_s) begin
      quot_s = {sign_s, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      quot_s = {sign_s, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      quot_s = {sign_s, 31'd0};
    end else begin
      quot_s = {sign_s, exp_s[7:0], frac_s[22:0]};
    end
  end

  // Fixed-latency result pipeline; the core has no reset
  always_ff @(posedge clock) begin
    stage_r[0] <= quot_s;
    for (int i = 1; i < LAT; i++) begin
      stage_r[i] <= stage_r[i-1];
    end
  end

  assign result = stage_r[LAT-1];

endmodule

// File: rtl/norm_div_pipe.sv
// Valid + payload delay line with synchronous clear; keeps write strobes
// aligned with quotients coming out of the divider.
module norm_div_pipe #(
  parameter int DEPTH = 15,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_r;
  logic [W-1:0]     data_r [DEPTH];

  // Shift valid and payload one stage per cycle; clear flushes every stage
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= {W{1'b0}};
      end
    end else begin
      valid_r   <= {valid_r[DEPTH-2:0], in_valid};
      data_r[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i] <= data_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/norm_div.sv
// Softmax normalisation: reads each exponential, divides by the latched sum,
// writes the probability out, then handshakes completion downstream.
module norm_div #(
  parameter int DATA_SIZE = norm_div_pkg::DATA_SIZE,
  parameter int DIV_DELAY = norm_div_pkg::DIV_DELAY
) (
  input logic       clk,
  input logic       rst,
  norm_div_if.slave bus
);
  import norm_div_pkg::*;

  localparam int            PIPE_DEPTH = 1 + DIV_DELAY;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] counter_r, counter_s;
  logic [DW-1:0] sum_r, sum_s;
  logic          ready_r;
  logic          issue_s, last_s;
  logic          pipe_valid_s;
  logic [AW:0]   pipe_data_s;

  // State, read counter, divisor and ready registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      counter_r <= {AW{1'b0}};
      sum_r     <= {DW{1'b0}};
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      counter_r <= counter_s;
      sum_r     <= sum_s;
      ready_r   <= (state_s == IDLE);
    end
  end

  // Next-state logic; the pipe's last-flag output marks the final write
  always_comb begin
    state_s   = state_r;
    counter_s = counter_r;
    sum_s     = sum_r;
    issue_s   = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.norm_div_start) begin
          sum_s     = bus.sum;
          counter_s = {AW{1'b0}};
          state_s   = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        issue_s = 1'b1;
        if (counter_r == LAST_ADDR) begin
          last_s  = 1'b1;
          state_s = DRAIN;
        end else begin
          counter_s = counter_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        if (pipe_data_s[AW]) begin
          state_s = bus.downstream_ready ? IDLE : HOLD;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        if (bus.downstream_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  norm_div_pipe #(
    .DEPTH (PIPE_DEPTH),
    .W     (AW + 1)
  ) u_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (issue_s),
    .in_data   ({last_s, counter_r}),
    .out_valid (pipe_valid_s),
    .out_data  (pipe_data_s)
  );

  fdiv14 u_div (
    .clock  (clk),
    .dataa  (bus.rd_data),
    .datab  (sum_r),
    .result (bus.wr_data)
  );

  assign bus.rd_addr        = counter_r;
  assign bus.wr_ena         = pipe_valid_s;
  assign bus.wr_addr        = pipe_data_s[AW-1:0];
  assign bus.norm_div_done  = pipe_data_s[AW];
  assign bus.norm_div_ready = ready_r;

endmodule

// File: doc/norm_div.md
# norm_div

Final stage of the softmax datapath. Once the exponent/sum stage has written its exponentials to the intermediate memory and produced their accumulated sum, this block reads each exponential back, divides it by the sum in IEEE-754 single precision, and writes the normalised probability to the output memory. Its handshake mirrors the upstream stage: start/ready on the input side, done/downstream_ready on the output side.

## Interface
- AW, 12, address width of the input and output memories
- DW, 32, data width (IEEE-754 single)
- DATA_SIZE, 128, number of elements per run (≥2, ≤2^AW)
- DIV_DELAY, 14, fixed pipeline latency of the floating-point divider core

- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- norm_div_start  input  1  start request, accepted only while norm_div_ready=1
- norm_div_ready  output  1  block idle and able to accept a start
- sum  input  DW  divisor; latched on the accepted start
- rd_addr  output  AW  read address into the exponential memory
- rd_data  input  DW  read data, valid one cycle after rd_addr
- wr_addr  output  AW  output memory write address
- wr_data  output  DW  quotient rd_data/sum
- wr_ena  output  1  output memory write strobe
- downstream_ready  input  1  consumer can accept a completed result set
- norm_div_done  output  1  one-cycle pulse after the last write

## Operation
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE: norm_div_ready=1. When norm_div_start=1: latch sum into sum_reg, clear the counter, move to RUN.
- RUN: rd_addr=counter, counter increments each cycle. When counter reaches DATA_SIZE-1, that address is issued and the state moves to DRAIN. Exactly DATA_SIZE reads, addresses 0..DATA_SIZE-1 in order, no gaps.
- The issue-valid bit and address enter a (1+DIV_DELAY)-deep valid/address delay line. Its output drives wr_ena and wr_addr.
- Divider: dataa=rd_data, datab=sum_reg. The result is wr_data, aligned with the delay-line output.
- DRAIN: waits until the delay line is empty, i.e. the last write has occurred. In that cycle norm_div_done pulses for one cycle. Next state is IDLE if downstream_ready=1, otherwise HOLD.
- HOLD: norm_div_ready=0. Move to IDLE on the first cycle with downstream_ready=1.
- A start while not in IDLE is ignored; sum_reg does not change.
- sum=0 or non-finite: no special handling. The divider's IEEE result (inf/NaN) is written unchanged.
- rd_addr holds its last value (DATA_SIZE-1) outside RUN. Reads outside RUN are harmless.

## Timing
- Reset values: norm_div_ready=1, norm_div_done=0, wr_ena=0, wr_addr=0, rd_addr=0. FSM=IDLE, counter=0, delay line cleared. wr_data is don't-care while wr_ena=0.
- Cycle t: start accepted. Cycle t+1: rd_addr=0 (first RUN cycle). Address k is issued at t+1+k.
- The write for address k occurs at cycle t+2+k+DIV_DELAY.
- The last write occurs at t+1+DATA_SIZE+DIV_DELAY. norm_div_done pulses in the same cycle.
- norm_div_ready rises at done+1 if downstream_ready=1 at done. Otherwise it rises one cycle after downstream_ready is first seen high.
- Back-to-back runs: minimum start-to-start interval is DATA_SIZE+DIV_DELAY+2 cycles.
- Reset asserted mid-run: at the next edge the FSM returns to IDLE and the delay line is flushed. wr_ena is 0 from that edge onward even though stale quotients remain inside the divider. norm_div_done does not pulse.

## Structure
- A shared softmax package/header holds: DW, AW, DATA_SIZE, and the IP latency constants (NORM_DELAY, EXP_DELAY, ACC_DELAY, DIV_DELAY), so that all softmax stages agree on them.
- FSM state encodings stay local to this block.
- Divider: the vendor single-precision divider core (fdiv14), instantiated directly.
- One sub-module: norm_div_pipe, a parameterised valid+address delay line with synchronous active-high clear, depth 1+DIV_DELAY. The existing delay cells use asynchronous reset, so they are not reused here.

## Test plan
- Basic run, DATA_SIZE=8, sum=4.0 (0x40800000), memory holds 1.0, 2.0, …, 8.0 → writes at addresses 0..7 of 0x3E800000 (0.25), 0x3F000000 (0.5), … 0x40000000 (2.0). Checks: exactly 8 wr_ena cycles, first write at t+2+DIV_DELAY, done coincident with the last write.
- Downstream_ready held low for 20 cycles after done → norm_div_ready stays 0 throughout. It rises exactly one cycle after downstream_ready goes high.
- Start pulsed mid-RUN with sum=1.0 → ignored. All outputs still use the original sum of 4.0, and no extra writes occur.
- Back-to-back runs: sum=2.0, then sum=8.0 at the minimum interval → the second run's outputs are all divided by 8.0, with no overlap of write addresses between runs.
- Reset asserted at address 3 of RUN → wr_ena=0 from the next edge, norm_div_ready=1, no done pulse. A subsequent run with sum=1.0 writes the memory contents unchanged.
- sum=0.0 with data 1.0 → wr_data=0x7F800000 (+inf) at every address, and the handshake completes normally.
